// File: rtl/tl_fifo_ordering_fixer.sv
// TileLink-UL FIFO-ordering adapter: stalls A when a FIFO domain would switch managers while busy.
// Optional stall statistics counter enabled by TL_FIFO_FIXER_STATS_EN.

module tl_fifo_domain #(
  parameter int CNT_W = 3,
  parameter int MGR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic [MGR_W-1:0] mgr_in,
  output logic [CNT_W-1:0] cnt,
  output logic [MGR_W-1:0] mgr
);
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      mgr <= '0;
    end else begin
      if (inc) mgr <= mgr_in;
      // A stray response on an idle domain is a client error; hold at zero rather than wrap.
      if (inc && !dec) cnt <= cnt + CNT_W'(1);
      else if (dec && !inc && cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

module tl_fifo_ordering_fixer #(
  parameter int SOURCE_W     = 6,
  parameter int DOMAIN_SHIFT = 3,
  parameter int ADDR_W       = 13,
  parameter int MGR_SHIFT    = 10,
  parameter int DATA_W       = 64,
  parameter int CNT_W        = 3
) (
  input  logic                clock,
  input  logic                reset,
  output logic                auto_in_a_ready,
  input  logic                auto_in_a_valid,
  input  logic [2:0]          auto_in_a_bits_opcode,
  input  logic [2:0]          auto_in_a_bits_param,
  input  logic [2:0]          auto_in_a_bits_size,
  input  logic [SOURCE_W-1:0] auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0] auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_a_bits_data,
  input  logic                auto_in_a_bits_corrupt,
  input  logic                auto_in_d_ready,
  output logic                auto_in_d_valid,
  output logic [2:0]          auto_in_d_bits_opcode,
  output logic [2:0]          auto_in_d_bits_size,
  output logic [SOURCE_W-1:0] auto_in_d_bits_source,
  output logic [DATA_W-1:0]   auto_in_d_bits_data,
  input  logic                auto_out_a_ready,
  output logic                auto_out_a_valid,
  output logic [2:0]          auto_out_a_bits_opcode,
  output logic [2:0]          auto_out_a_bits_param,
  output logic [2:0]          auto_out_a_bits_size,
  output logic [SOURCE_W-1:0] auto_out_a_bits_source,
  output logic [ADDR_W-1:0]   auto_out_a_bits_address,
  output logic [DATA_W/8-1:0] auto_out_a_bits_mask,
  output logic [DATA_W-1:0]   auto_out_a_bits_data,
  output logic                auto_out_a_bits_corrupt,
  output logic                auto_out_d_ready,
  input  logic                auto_out_d_valid,
  input  logic [2:0]          auto_out_d_bits_opcode,
  input  logic [2:0]          auto_out_d_bits_size,
  input  logic [SOURCE_W-1:0] auto_out_d_bits_source,
  input  logic [DATA_W-1:0]   auto_out_d_bits_data,
  output logic [31:0]         stall_cycles
);
  localparam int DOM_W       = SOURCE_W - DOMAIN_SHIFT;
  localparam int NUM_DOMAINS = 1 << DOM_W;
  localparam int MGR_W       = ADDR_W - MGR_SHIFT;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_DOMAINS-1:0][CNT_W-1:0] cnt;
  logic [NUM_DOMAINS-1:0][MGR_W-1:0] mgr;
  logic [DOM_W-1:0] dom_a, dom_d;
  logic [MGR_W-1:0] mgr_a;
  logic stall, a_fire, d_fire;

  assign dom_a = auto_in_a_bits_source[SOURCE_W-1:DOMAIN_SHIFT];
  assign dom_d = auto_out_d_bits_source[SOURCE_W-1:DOMAIN_SHIFT];
  assign mgr_a = auto_in_a_bits_address[ADDR_W-1:MGR_SHIFT];

  // A full counter also stalls, so increments can never wrap.
  assign stall = (cnt[dom_a] != '0 && mgr[dom_a] != mgr_a) || (cnt[dom_a] == CNT_MAX);

  assign auto_out_a_valid        = auto_in_a_valid & ~stall;
  assign auto_in_a_ready         = auto_out_a_ready & ~stall;
  assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
  assign auto_out_a_bits_param   = auto_in_a_bits_param;
  assign auto_out_a_bits_size    = auto_in_a_bits_size;
  assign auto_out_a_bits_source  = auto_in_a_bits_source;
  assign auto_out_a_bits_address = auto_in_a_bits_address;
  assign auto_out_a_bits_mask    = auto_in_a_bits_mask;
  assign auto_out_a_bits_data    = auto_in_a_bits_data;
  assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;

  assign auto_in_d_valid       = auto_out_d_valid;
  assign auto_out_d_ready      = auto_in_d_ready;
  assign auto_in_d_bits_opcode = auto_out_d_bits_opcode;
  assign auto_in_d_bits_size   = auto_out_d_bits_size;
  assign auto_in_d_bits_source = auto_out_d_bits_source;
  assign auto_in_d_bits_data   = auto_out_d_bits_data;

  assign a_fire = auto_out_a_valid & auto_out_a_ready;
  assign d_fire = auto_out_d_valid & auto_in_d_ready;

  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    tl_fifo_domain #(.CNT_W(CNT_W), .MGR_W(MGR_W)) u_dom (
      .clock  (clock),
      .reset  (reset),
      .inc    (a_fire && dom_a == DOM_W'(g)),
      .dec    (d_fire && dom_d == DOM_W'(g)),
      .mgr_in (mgr_a),
      .cnt    (cnt[g]),
      .mgr    (mgr[g])
    );
  end

`ifdef TL_FIFO_FIXER_STATS_EN
  logic [31:0] stall_q;
  always_ff @(posedge clock) begin
    if (reset) stall_q <= '0;
    else if (auto_in_a_valid && stall && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: doc/tl_fifo_ordering_fixer.md
Name: tl_fifo_ordering_fixer

Overview:
- TileLink-UL FIFO-ordering adapter placed between a client crossbar port and a single manager-side link.
- Sources are grouped into FIFO domains. A domain may only have requests outstanding to one manager at a time.
- A request that would target a different manager than the domain's outstanding requests is stalled on A until that domain drains.
- Zero-latency, combinational pass-through when no stall applies. D channel is a pure pass-through plus bookkeeping.

Parameters:
- SOURCE_W, 6, A/D source id width.
- DOMAIN_SHIFT, 3, domain = source >> DOMAIN_SHIFT; NUM_DOMAINS = 2^(SOURCE_W-DOMAIN_SHIFT).
- ADDR_W, 13, A address width.
- MGR_SHIFT, 10, manager id = address[ADDR_W-1:MGR_SHIFT]; MGR_W = ADDR_W-MGR_SHIFT.
- DATA_W, 64, data width; MASK_W = DATA_W/8.
- CNT_W, 3, per-domain outstanding counter width; CNT_MAX = 2^CNT_W-1.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- auto_in_a_ready  out  1  A ready to client
- auto_in_a_valid  in  1  A valid from client
- auto_in_a_bits_opcode/param/size  in  3 each  A fields
- auto_in_a_bits_source  in  SOURCE_W  A source
- auto_in_a_bits_address  in  ADDR_W  A address
- auto_in_a_bits_mask  in  MASK_W  A mask
- auto_in_a_bits_data  in  DATA_W  A data
- auto_in_a_bits_corrupt  in  1  A corrupt
- auto_in_d_ready  in  1  D ready from client
- auto_in_d_valid  out  1  D valid to client
- auto_in_d_bits_opcode/size  out  3 each  D fields
- auto_in_d_bits_source  out  SOURCE_W  D source
- auto_in_d_bits_data  out  DATA_W  D data
- auto_out_a_*  mirror of auto_in_a_* with direction reversed (ready in, valid/bits out)
- auto_out_d_*  mirror of auto_in_d_* with direction reversed (ready out, valid/bits in)
- stall_cycles  out  32  saturating count of cycles with auto_in_a_valid & stall

Behaviour:
- Per domain d, registered state:
  - cnt[d] (CNT_W bits), reset 0.
  - mgr[d] (MGR_W bits), reset 0.
- Decode: dA = a_source>>DOMAIN_SHIFT; mA = a_address>>MGR_SHIFT; dD = d_source>>DOMAIN_SHIFT.
- stall = (cnt[dA]!=0 & mgr[dA]!=mA) | (cnt[dA]==CNT_MAX). Combinational, no added latency.
- Outputs:
  - auto_out_a_valid = auto_in_a_valid & !stall.
  - auto_in_a_ready = auto_out_a_ready & !stall.
  - All A bits pass through unchanged.
- D channel: valid, ready and bits pass through unchanged; never stalled.
- a_fire = auto_out_a_valid & auto_out_a_ready. d_fire = auto_out_d_valid & auto_in_d_ready.
- All transfers are single-beat; a_size <= log2(MASK_W) is required of the client.
- Next-cycle counter update:
  - a_fire only: cnt[dA]+1; mgr[dA] <= mA.
  - d_fire only: cnt[dD]-1.
  - Both with dA==dD: cnt unchanged; mgr[dA] <= mA. This is legal only because stall was false, so mA equals mgr or cnt was 0.
  - Both with dA!=dD: each domain updates independently.
- cnt never wraps:
  - Increment is blocked at CNT_MAX by the stall.
  - d_fire with cnt[dD]==0 is a protocol error; cnt holds at 0.
- Stall only gates valid/ready, so a stalled request stays visible on the input. The client must hold A stable per TileLink rules.
- stall_cycles:
  - +1 per cycle when auto_in_a_valid & stall.
  - Saturates at 0xFFFFFFFF.
  - Reset to 0.
- Reset values: all cnt 0, all mgr 0, stall_cycles 0.
  - Outputs after reset are pure functions of inputs: stall=0, so valid/ready pass through.
- Reset asserted mid-operation: state clears on the next edge. Responses to requests issued before reset are dropped by the client; the counters do not track them.

Optional Feature:
- Macro: TL_FIFO_FIXER_STATS_EN.
- Defined: stall_cycles counter is implemented as described.
- Undefined: stall_cycles is tied to 32'h0 and no counter flops are instantiated; the port remains present.

Test Plan:
- Reset, then A source 0x00, address 0x0400, out ready=1 -> out_a_valid same cycle; cnt[0]=1, mgr[0]=1 next cycle.
- Domain 0 with 1 outstanding to mgr 1; A source 0x01 to address 0x0800 -> in_a_ready=0, out_a_valid=0 until D source 0x00 fires; request passes the cycle after.
- Same domain and same manager, 7 requests to address 0x0400 with no D returns -> 8th request stalled (cnt=7=CNT_MAX); one D return -> 8th request passes.
- Same-cycle A fire and D fire in domain 2 (sources 0x10/0x11), same manager -> cnt[2] unchanged.
- Domain 0 stalled on a manager conflict while domain 1 (source 0x08) targets a different manager -> domain 1 passes with no stall.
- With TL_FIFO_FIXER_STATS_EN defined, hold a conflicting request for 5 cycles -> stall_cycles=5. Without the macro -> stall_cycles=0.
